ar4_operand_sequencer: RTL and testbench

Initiator-side front end for the AR4 accelerator. It turns raw board push-buttons and the 8-bit switch bank into clean, single-cycle operand-load strobes (getA, getX) with stable data (swOut), issues the startAR4 request, and waits for readyAR4. On ready it captures the 32-bit result for the hex-display path. It sits between the board I/O pins and the accelerator top, driving the side that the accelerator receives.

---
 rtl/ar4_operand_sequencer.sv | 99 +++++++++
 tb/tb_ar4_operand_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ar4_operand_sequencer.sv
// ar4_operand_sequencer: debounces board buttons into operand-load and start strobes
// for the AR4 accelerator, then waits for its ready and captures the result.
module ar4_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  swData,
  input  logic        btnA,
  input  logic        btnX,
  input  logic        btnGo,
  input  logic        readyAR4,
  input  logic [31:0] resultIn,
  output logic [7:0]  swOut,
  output logic        getA,
  output logic        getX,
  output logic        startAR4,
  output logic        busy,
  output logic [31:0] resultOut,
  output logic        done,
  output logic        timeout
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_sw_s1, r_sw_s2, r_sw_out;
  logic [2:0]      r_btn_s1, r_btn_s2, r_deb, r_deb_d, r_pend;
  logic [DW-1:0]   r_dcnt [3];
  logic [TW-1:0]   r_tcnt;
  logic [31:0]     r_result;
  logic            r_done, r_timeout;
  logic [2:0]      w_rise, w_serve;
  logic            w_cap, w_tmo;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= swData;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= {btnGo, btnX, btnA};
      r_btn_s2 <= r_btn_s1;
    end
  // The level flips on the mismatching sample that follows DEBOUNCE_CYCLES counted ones
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_deb <= '0;
      for (int b = 0; b < 3; b++) r_dcnt[b] <= '0;
    end else begin
      for (int b = 0; b < 3; b++)
        if (r_btn_s2[b] == r_deb[b]) r_dcnt[b] <= '0;
        else if (r_dcnt[b] == DW'(DEBOUNCE_CYCLES)) begin
          r_dcnt[b] <= '0;
          r_deb[b]  <= r_btn_s2[b];
        end else r_dcnt[b] <= r_dcnt[b] + 1'b1;
    end
  always_comb begin
    w_rise  = r_deb & ~r_deb_d;
    w_serve = (r_state != IDLE) ? 3'b000 :
              r_pend[0] ? 3'b001 : r_pend[1] ? 3'b010 : r_pend[2] ? 3'b100 : 3'b000;
    w_cap   = (r_state == WAIT) && readyAR4;
    w_tmo   = (r_state == WAIT) && !readyAR4 && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    w_next  = w_serve[2] ? START : (r_state == START) ? WAIT : (w_cap || w_tmo) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_deb_d   <= '0;
      r_pend    <= '0;
      r_sw_out  <= '0;
      r_tcnt    <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_deb_d   <= r_deb;
      r_pend    <= (r_state == IDLE) ? (r_pend | w_rise) & ~w_serve : 3'b000;
      r_sw_out  <= (w_serve[0] || w_serve[1]) ? r_sw_s2 : r_sw_out;
      r_tcnt    <= w_serve[2] ? '0 : (r_state == WAIT) ? r_tcnt + 1'b1 : r_tcnt;
      r_result  <= w_cap ? resultIn : r_result;
      r_done    <= w_serve[2] ? 1'b0 : w_cap ? 1'b1 : r_done;
      r_timeout <= w_serve[2] ? 1'b0 : w_tmo ? 1'b1 : r_timeout;
    end
  // Operand data is forwarded during the load strobe so it is valid in that same cycle
  assign swOut     = (w_serve[0] || w_serve[1]) ? r_sw_s2 : r_sw_out;
  assign getA      = w_serve[0];
  assign getX      = w_serve[1];
  assign startAR4  = w_serve[2];
  assign busy      = (r_state == START) || (r_state == WAIT);
  assign resultOut = r_result;
  assign done      = r_done;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_ar4_operand_sequencer.sv
// tb_ar4_operand_sequencer: scoreboard bench; stimulus pushes expected events with their
// cycle numbers, a negedge monitor pops and compares whenever the DUT signals one.
module tb_ar4_operand_sequencer;
  localparam int DEB = 4;
  localparam int TO  = 8;
  localparam int LAT = DEB + 4;
  localparam int K_A = 0, K_X = 1, K_GO = 2, K_RES = 3, K_TMO = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  swData = '0;
  logic        btnA = 1'b0, btnX = 1'b0, btnGo = 1'b0, readyAR4 = 1'b0;
  logic [31:0] resultIn = '0;
  logic [7:0]  swOut;
  logic        getA, getX, startAR4, busy, done, timeout;
  logic [31:0] resultOut;
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;
  ev_t         q[$];
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] last_res = '0;
  logic [7:0]  last_sw = '0;
  logic        prev_done = 1'b0, prev_tmo = 1'b0;

  ar4_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .swData(swData), .btnA(btnA), .btnX(btnX), .btnGo(btnGo),
    .readyAR4(readyAR4), .resultIn(resultIn), .swOut(swOut), .getA(getA), .getX(getX),
    .startAR4(startAR4), .busy(busy), .resultOut(resultOut), .done(done), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic got(input int kind, input logic [31:0] data);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected none", kind, data, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (getA || getX || startAR4) begin
        chk("strobe_onehot", 32'(getA) + 32'(getX) + 32'(startAR4), 1);
        if (getA) got(K_A, {24'b0, swOut});
        else if (getX) got(K_X, {24'b0, swOut});
        else got(K_GO, 0);
      end
      if (done && !prev_done) begin
        got(K_RES, resultOut);
        chk("busy_at_done", busy, 0);
      end
      if (timeout && !prev_tmo) begin
        got(K_TMO, resultOut);
        chk("busy_at_timeout", busy, 0);
      end
    end
    prev_done = done;
    prev_tmo  = timeout;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // Model: a clean press driven in cycle t0 becomes pending so that the IDLE server
  // can act in cycle t0+LAT; simultaneous pendings are served one per cycle, A, X, Go.
  task automatic txn(input logic [2:0] mask, input logic [7:0] sw, input int mode,
                     input logic [31:0] res, input bit bounce, input bit a_in_wait);
    int t0, slot, s_cyc, cap;
    swData = sw;
    if (bounce)
      for (int j = 0; j < 10; j++) begin
        btnA = ~j[0];
        tick(2);
      end
    {btnGo, btnX, btnA} = mask;
    t0    = cyc;
    slot  = t0 + LAT;
    s_cyc = 0;
    for (int b = 0; b < 3; b++)
      if (mask[b]) begin
        q.push_back('{b, (b < 2) ? {24'b0, sw} : 32'b0, slot});
        if (b == 2) s_cyc = slot;
        slot++;
      end
    if (mask[1:0] != 2'b00) last_sw = sw;
    if (mask[2]) begin
      cap = (mode > 0) ? s_cyc + ((mode < 2) ? 2 : mode) + 1 : s_cyc + 2 + TO;
      q.push_back('{(mode > 0) ? K_RES : K_TMO, (mode > 0) ? res : last_res, cap});
      if (mode > 0) last_res = res;
      if (a_in_wait) begin
        wait_until(s_cyc - 4);
        btnA = 1'b1;
      end
      wait_until(s_cyc + 1);
      chk("busy_after_go", busy, 1);
      chk("done_cleared_by_go", done, 0);
      chk("timeout_cleared_by_go", timeout, 0);
      if (mode > 0) begin
        wait_until(s_cyc + mode);
        readyAR4 = 1'b1;
        resultIn = res;
      end
      wait_until(cap + 1);
      readyAR4 = 1'b0;
      resultIn = $urandom;
    end else wait_until(slot + 2);
    {btnGo, btnX, btnA} = 3'b000;
    tick(DEB + 8);
    chk("swOut_hold", swOut, last_sw);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t0, s;
    tick(3);
    chk("rst_swOut", swOut, 0);
    chk("rst_strobes", {getA, getX, startAR4}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resultOut", resultOut, 0);
    chk("rst_done_timeout", {done, timeout}, 0);
    rst = 1'b0;
    tick(2);
    txn(3'b001, 8'h5A, 0, 0, 1'b1, 1'b0);
    txn(3'b001, 8'h12, 0, 0, 1'b0, 1'b0);
    txn(3'b010, 8'h34, 0, 0, 1'b0, 1'b0);
    txn(3'b100, 8'h77, 5, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("resultOut_handshake", resultOut, 32'hDEADBEEF);
    chk("done_handshake", done, 1);
    txn(3'b111, 8'hC3, 3, $urandom, 1'b0, 1'b0);
    txn(3'b100, 8'h00, 0, 0, 1'b0, 1'b0);
    chk("timeout_sticky", timeout, 1);
    txn(3'b100, 8'h00, 7, $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      txn(3'($urandom_range(1, 7)), 8'($urandom), $urandom_range(0, 7), $urandom, 1'b0, 1'b0);
    btnGo = 1'b1;
    t0 = cyc;
    s = t0 + LAT;
    q.push_back('{K_GO, 32'b0, s});
    wait_until(s + 1);
    btnGo = 1'b0;
    wait_until(s + 4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_swOut", swOut, 0);
    chk("async_rst_strobes", {getA, getX, startAR4}, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_resultOut", resultOut, 0);
    chk("async_rst_done_timeout", {done, timeout}, 0);
    tick(1);
    rst = 1'b0;
    last_res = '0;
    last_sw  = '0;
    readyAR4 = 1'b1;
    resultIn = 32'hCAFEF00D;
    tick(4);
    chk("no_capture_after_rst", resultOut, 0);
    chk("no_done_after_rst", done, 0);
    readyAR4 = 1'b0;
    tick(DEB + 8);
    chk("idle_after_rst", busy, 0);
    while (q.size() != 0) begin
      ev_t e;
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_event: kind %0d expected at cycle %0d never seen", e.kind, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
